// File: rtl/operand_pkg.sv
// Shared opcode constants, fill-state encoding and opcode classification helpers
// for the operand capture stage.
package operand_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_OP    = 7'b0110011;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    function automatic logic is_itype(input logic [6:0] opc);
        return (opc == OPC_LOAD) || (opc == OPC_OPIMM) || (opc == OPC_JALR);
    endfunction

    function automatic logic is_rtype(input logic [6:0] opc);
        return (opc == OPC_OP);
    endfunction

endpackage

// File: rtl/operand_latch_if.sv
// Decode->execute operand handshake bundle: upstream offer, forwarding bus,
// downstream head entry and flush. slave = the latch, master = its environment.
interface operand_latch_if #(
    parameter int XLEN = 32,
    parameter int NSRC = 2,
    parameter int AW   = 5
);
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [6:0]             in_opcode;
    logic [NSRC*AW-1:0]     in_rs_addr;
    logic [NSRC*XLEN-1:0]   in_rf_data;
    logic [XLEN-1:0]        in_imm;
    logic                   fwd_valid;
    logic [AW-1:0]          fwd_addr;
    logic [XLEN-1:0]        fwd_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [6:0]             out_opcode;
    logic [NSRC*XLEN-1:0]   out_op;
    logic                   out_illegal;

    modport slave (
        input  flush, in_valid, in_opcode, in_rs_addr, in_rf_data, in_imm,
        input  fwd_valid, fwd_addr, fwd_data, out_ready,
        output in_ready, out_valid, out_opcode, out_op, out_illegal
    );

    modport master (
        output flush, in_valid, in_opcode, in_rs_addr, in_rf_data, in_imm,
        output fwd_valid, fwd_addr, fwd_data, out_ready,
        input  in_ready, out_valid, out_opcode, out_op, out_illegal
    );
endinterface

// File: rtl/operand_mux.sv
// Per-channel operand select: immediate (channel 1 on I-type), x0 zero,
// writeback forward, else register-file data. Purely combinational, no backpressure.
module operand_mux
    import operand_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int CH   = 0
) (
    input  logic            itype_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [XLEN-1:0] rf_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic            fwd_vld_i,
    input  logic [AW-1:0]   fwd_addr_i,
    input  logic [XLEN-1:0] fwd_data_i,
    output logic [XLEN-1:0] op_o
);

    always_comb begin
        op_o = rf_i;
        if (CH == 1 && itype_i) begin
            op_o = imm_i;
        end else if (addr_i == '0) begin
            op_o = '0;
        end else if (fwd_vld_i && (fwd_addr_i == addr_i)) begin
            op_o = fwd_data_i;
        end
    end

endmodule

// File: rtl/operand_latch.sv
// Operand capture stage: selects NSRC operands and holds them in a 2-entry skid buffer.
// Latency 1 cycle accept->out_valid; in_ready registered, low only while both entries full.
// OPERAND_REFRESH_EN: buffered register operands snoop the writeback bus every cycle.
module operand_latch
    import operand_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NSRC = 2,
    parameter int AW   = 5
) (
    input  logic          clk,
    input  logic          rst,
    operand_latch_if.slave bus
);

    localparam int OPW = NSRC * XLEN;

    state_t           state_q, state_d;
    logic             in_ready_q;
    logic             accept, pop;
    logic             ld0, ld1, shift;

    logic [6:0]       opc_q [2];
    logic [OPW-1:0]   op_q  [2];
    logic             ill_q [2];
    logic [6:0]       opc_d [2];
    logic [OPW-1:0]   op_d  [2];
    logic             ill_d [2];
    logic [OPW-1:0]   op_ref [2];

    logic [OPW-1:0]   cap_op;
    logic             cap_itype;
    logic             cap_ill;

    assign cap_itype = is_itype(bus.in_opcode);
    assign cap_ill   = !(cap_itype || is_rtype(bus.in_opcode));

    for (genvar i = 0; i < NSRC; i++) begin : g_mux
        operand_mux #(
            .XLEN (XLEN),
            .AW   (AW),
            .CH   (i)
        ) u_mux (
            .itype_i    (cap_itype),
            .addr_i     (bus.in_rs_addr[i*AW +: AW]),
            .rf_i       (bus.in_rf_data[i*XLEN +: XLEN]),
            .imm_i      (bus.in_imm),
            .fwd_vld_i  (bus.fwd_valid),
            .fwd_addr_i (bus.fwd_addr),
            .fwd_data_i (bus.fwd_data),
            .op_o       (cap_op[i*XLEN +: XLEN])
        );
    end

    assign accept = bus.in_valid && in_ready_q;
    assign pop    = (state_q != ST_EMPTY) && bus.out_ready;

    // Slot 0 is always the head; slot 1 only ever holds the younger entry.
    always_comb begin
        state_d = state_q;
        ld0     = 1'b0;
        ld1     = 1'b0;
        shift   = 1'b0;
        if (bus.flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        ld0     = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        ld0 = 1'b1;
                    end else if (accept) begin
                        state_d = ST_TWO;
                        ld1     = 1'b1;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        state_d = ST_ONE;
                        shift   = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

`ifdef OPERAND_REFRESH_EN
    logic [NSRC*AW-1:0] addr_q  [2];
    logic               itype_q [2];

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            op_ref[s] = op_q[s];
            for (int i = 0; i < NSRC; i++) begin
                if (bus.fwd_valid && !(i == 1 && itype_q[s]) &&
                    (addr_q[s][i*AW +: AW] != '0) &&
                    (addr_q[s][i*AW +: AW] == bus.fwd_addr)) begin
                    op_ref[s][i*XLEN +: XLEN] = bus.fwd_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                addr_q[s]  <= '0;
                itype_q[s] <= 1'b0;
            end
        end else begin
            if (ld0) begin
                addr_q[0]  <= bus.in_rs_addr;
                itype_q[0] <= cap_itype;
            end else if (shift) begin
                addr_q[0]  <= addr_q[1];
                itype_q[0] <= itype_q[1];
            end
            if (ld1) begin
                addr_q[1]  <= bus.in_rs_addr;
                itype_q[1] <= cap_itype;
            end
        end
    end
`else
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            op_ref[s] = op_q[s];
        end
    end
`endif

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            opc_d[s] = opc_q[s];
            op_d[s]  = op_ref[s];
            ill_d[s] = ill_q[s];
        end
        if (ld0) begin
            opc_d[0] = bus.in_opcode;
            op_d[0]  = cap_op;
            ill_d[0] = cap_ill;
        end else if (shift) begin
            opc_d[0] = opc_q[1];
            op_d[0]  = op_ref[1];
            ill_d[0] = ill_q[1];
        end
        if (ld1) begin
            opc_d[1] = bus.in_opcode;
            op_d[1]  = cap_op;
            ill_d[1] = cap_ill;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            for (int s = 0; s < 2; s++) begin
                opc_q[s] <= '0;
                op_q[s]  <= '0;
                ill_q[s] <= 1'b0;
            end
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_TWO);
            for (int s = 0; s < 2; s++) begin
                opc_q[s] <= opc_d[s];
                op_q[s]  <= op_d[s];
                ill_q[s] <= ill_d[s];
            end
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = (state_q != ST_EMPTY);
    assign bus.out_opcode  = opc_q[0];
    assign bus.out_op      = op_q[0];
    assign bus.out_illegal = ill_q[0];

endmodule

// File: tb/tb_operand_latch.sv
// Self-checking bench for operand_latch: directed scenarios plus random traffic
// scored against a queue-based model of the two-entry operand buffer.
module tb_operand_latch;

    localparam int XLEN = 32;
    localparam int NSRC = 2;
    localparam int AW   = 5;

    typedef struct {
        logic [6:0]           opc;
        logic [NSRC*XLEN-1:0] ops;
        logic                 ill;
        logic [NSRC*AW-1:0]   addr;
        logic                 itype;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    ent_t q[$];

    operand_latch_if #(.XLEN(XLEN), .NSRC(NSRC), .AW(AW)) bus ();

    operand_latch #(.XLEN(XLEN), .NSRC(NSRC), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ent_t mk_entry();
        ent_t e;
        logic [AW-1:0] a;
        e.opc   = bus.in_opcode;
        e.addr  = bus.in_rs_addr;
        e.itype = (bus.in_opcode == 7'h03) || (bus.in_opcode == 7'h13) || (bus.in_opcode == 7'h67);
        e.ill   = !(e.itype || bus.in_opcode == 7'h33);
        e.ops   = '0;
        for (int i = 0; i < NSRC; i++) begin
            a = bus.in_rs_addr[i*AW +: AW];
            if (i == 1 && e.itype)                        e.ops[i*XLEN +: XLEN] = bus.in_imm;
            else if (a == 0)                              e.ops[i*XLEN +: XLEN] = '0;
            else if (bus.fwd_valid && bus.fwd_addr == a)  e.ops[i*XLEN +: XLEN] = bus.fwd_data;
            else                                          e.ops[i*XLEN +: XLEN] = bus.in_rf_data[i*XLEN +: XLEN];
        end
        return e;
    endfunction

    task automatic drive(input logic v, input logic [6:0] opc, input logic [AW-1:0] a0,
                         input logic [AW-1:0] a1, input logic [XLEN-1:0] r0, input logic [XLEN-1:0] r1,
                         input logic [XLEN-1:0] imm, input logic fv, input logic [AW-1:0] fa,
                         input logic [XLEN-1:0] fd, input logic ordy, input logic fl);
        bus.in_valid   = v;
        bus.in_opcode  = opc;
        bus.in_rs_addr = {a1, a0};
        bus.in_rf_data = {r1, r0};
        bus.in_imm     = imm;
        bus.fwd_valid  = fv;
        bus.fwd_addr   = fa;
        bus.fwd_data   = fd;
        bus.out_ready  = ordy;
        bus.flush      = fl;
    endtask

    // One clock: score outputs mid-cycle, then advance the model at the edge.
    task automatic cyc();
        logic acc, pp;
        ent_t e;
        @(negedge clk);
        check("out_valid", bus.out_valid, q.size() != 0);
        check("in_ready", bus.in_ready, q.size() < 2);
        if (q.size() != 0) begin
            check("out_opcode", bus.out_opcode, q[0].opc);
            check("out_op", bus.out_op, q[0].ops);
            check("out_illegal", bus.out_illegal, q[0].ill);
        end
        @(posedge clk);
        acc = bus.in_valid && (q.size() < 2);
        pp  = (q.size() != 0) && bus.out_ready;
        if (bus.flush) begin
            q.delete();
        end else begin
            if (pp) void'(q.pop_front());
`ifdef OPERAND_REFRESH_EN
            for (int k = 0; k < q.size(); k++) begin
                e = q[k];
                for (int i = 0; i < NSRC; i++) begin
                    if (bus.fwd_valid && !(i == 1 && e.itype) && e.addr[i*AW +: AW] != 0 &&
                        e.addr[i*AW +: AW] == bus.fwd_addr)
                        e.ops[i*XLEN +: XLEN] = bus.fwd_data;
                end
                q[k] = e;
            end
`endif
            if (acc) q.push_back(mk_entry());
        end
        #1;
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 7'h00, 0, 0, 0, 0, 0, 1'b0, 0, 0, ordy, 1'b0);
    endtask

    initial begin
        logic [6:0] opc;
        logic [6:0] opc_tab [5];
        opc_tab[0] = 7'h03; opc_tab[1] = 7'h13; opc_tab[2] = 7'h67; opc_tab[3] = 7'h33; opc_tab[4] = 7'h7F;

        idle(1'b0);
        #12;
        check("rst out_valid", bus.out_valid, 1'b0);
        check("rst in_ready", bus.in_ready, 1'b1);
        check("rst out_opcode", bus.out_opcode, 7'h00);
        check("rst out_op", bus.out_op, 64'h0);
        check("rst out_illegal", bus.out_illegal, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // OP-IMM: rs1 from regfile, channel 1 from immediate
        drive(1'b1, 7'h13, 3, 9, 32'h10, 32'hDEAD, 32'h5, 1'b0, 0, 0, 1'b1, 1'b0);
        cyc();
        idle(1'b1);
        check("opimm op0", bus.out_op[31:0], 32'h10);
        check("opimm op1", bus.out_op[63:32], 32'h5);
        cyc();

        // R-type forwarding, then x0 beats forwarding
        drive(1'b1, 7'h33, 4, 2, 32'h1, 32'h2, 0, 1'b1, 4, 32'hAA, 1'b1, 1'b0);
        cyc();
        check("fwd op0", bus.out_op[31:0], 32'hAA);
        drive(1'b1, 7'h33, 0, 2, 32'h1, 32'h2, 0, 1'b1, 0, 32'hAA, 1'b1, 1'b0);
        cyc();
        check("x0 op0", bus.out_op[31:0], 32'h0);

        // Stall with three offers, then release
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 7'h33, 5, 6, 32'h100 + k, 32'h200 + k, 0, 1'b0, 0, 0, 1'b0, 1'b0);
            cyc();
            if (k == 1) check("ready low after 2nd", bus.in_ready, 1'b0);
        end
        drive(1'b1, 7'h33, 5, 6, 32'h102, 32'h202, 0, 1'b0, 0, 0, 1'b1, 1'b0);
        cyc();
        cyc();
        idle(1'b1);
        repeat (3) cyc();

        // Illegal opcode, then flush with both entries full and an offer present
        drive(1'b1, 7'h7F, 1, 2, 32'h11, 32'h22, 0, 1'b0, 0, 0, 1'b0, 1'b0);
        cyc();
        check("illegal", bus.out_illegal, 1'b1);
        drive(1'b1, 7'h13, 1, 2, 32'h33, 32'h44, 32'h7, 1'b0, 0, 0, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 7'h33, 1, 2, 32'h55, 32'h66, 0, 1'b0, 0, 0, 1'b0, 1'b1);
        cyc();
        check("flush out_valid", bus.out_valid, 1'b0);
        check("flush in_ready", bus.in_ready, 1'b1);
        idle(1'b1);
        cyc();

        // Stalled entry snoops writeback on rs2=7
        drive(1'b1, 7'h33, 3, 7, 32'h31, 32'h1234, 0, 1'b0, 0, 0, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 7'h00, 0, 0, 0, 0, 0, 1'b1, 7, 32'h55, 1'b0, 1'b0);
        cyc();
`ifdef OPERAND_REFRESH_EN
        check("refresh op1", bus.out_op[63:32], 32'h55);
`else
        check("frozen op1", bus.out_op[63:32], 32'h1234);
`endif
        idle(1'b1);
        repeat (2) cyc();

        // Asynchronous reset mid-transfer
        drive(1'b1, 7'h33, 1, 2, 32'h77, 32'h88, 0, 1'b0, 0, 0, 1'b0, 1'b0);
        repeat (2) cyc();
        idle(1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst out_valid", bus.out_valid, 1'b0);
        check("arst in_ready", bus.in_ready, 1'b1);
        check("arst out_op", bus.out_op, 64'h0);
        check("arst out_opcode", bus.out_opcode, 7'h00);
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            opc = ($urandom_range(0, 9) == 0) ? 7'($urandom) : opc_tab[$urandom_range(0, 3)];
            drive($urandom_range(0, 9) < 7, opc,
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                  $urandom, $urandom, $urandom,
                  $urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
            cyc();
        end
        idle(1'b1);
        repeat (3) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
